// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame constants and the
// command bytes understood by the downstream decoder.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    localparam int         DATA_BITS = 8;
    localparam logic [3:0] MID_TICK  = 4'd7;
    localparam logic [3:0] LAST_TICK = 4'd15;

    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_U = 8'h55;

    // Clock cycles per sample tick, truncated, never allowed below one.
    function automatic int calc_tick_div(input int clk_freq, input int baud, input int oversample);
        int div;
        div = clk_freq / (baud * oversample);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_baud_tick_gen.sv
// Free-running sample tick generator: one-cycle tick every TICK_DIV clocks.
// Shared between the UART receiver and transmitter.
module baud_tick_gen #(
    parameter int TICK_DIV = 651
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // With TICK_DIV == 1 the counter stays at zero and tick is always high.
    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, 2-flop input synchronizer and
// start/stop bit validation. state_dbg exposes the FSM state for checkers.
//
// Output handshake: rx_done is a one-cycle valid strobe with no ready; rx_data
// is valid in the rx_done cycle and holds until the next good frame.
// frame_err is a one-cycle strobe, never coincident with rx_done.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output state_t     state_dbg
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);

    logic tick;

    baud_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Synchronizer flops reset to the idle line level.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    state_t         state,     state_n;
    logic [3:0]     tick_cnt,  tick_cnt_n;
    logic [2:0]     bit_cnt,   bit_cnt_n;
    logic [7:0]     shift_reg, shift_reg_n;
    logic [7:0]     rx_data_n;
    logic           rx_done_n;
    logic           frame_err_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            tick_cnt  <= tick_cnt_n;
            bit_cnt   <= bit_cnt_n;
            shift_reg <= shift_reg_n;
            rx_data   <= rx_data_n;
            rx_done   <= rx_done_n;
            frame_err <= frame_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        tick_cnt_n  = tick_cnt;
        bit_cnt_n   = bit_cnt;
        shift_reg_n = shift_reg;
        rx_data_n   = rx_data;
        rx_done_n   = 1'b0;
        frame_err_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n    = START;
                    tick_cnt_n = '0;
                end
            end

            // Re-check the line at the middle of the start bit to reject glitches.
            START: begin
                if (tick) begin
                    if (tick_cnt == MID_TICK) begin
                        tick_cnt_n = '0;
                        bit_cnt_n  = '0;
                        state_n    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            DATA: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n  = '0;
                        shift_reg_n = {rx_s, shift_reg[7:1]};
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state_n = STOP;
                        end else begin
                            bit_cnt_n = bit_cnt + 3'd1;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            // Leaving at the stop-bit midpoint leaves half a bit to catch the next start.
            STOP: begin
                if (tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_cnt_n = '0;
                        if (rx_s) begin
                            rx_data_n = shift_reg;
                            rx_done_n = 1'b1;
                            state_n   = IDLE;
                        end else begin
                            frame_err_n = 1'b1;
                            state_n     = WAIT_IDLE;
                        end
                    end else begin
                        tick_cnt_n = tick_cnt + 4'd1;
                    end
                end
            end

            // A break or stuck-low line must go high before a new start is accepted.
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign rx_busy   = (state == START) || (state == DATA) || (state == STOP);
    assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus
// randomized frames checked against a byte-level expected queue.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int      CLK_HALF = 50;
    localparam realtime BIT_T    = 1600.0;  // 16 clocks of 100 units

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    state_t     state_dbg;

    uart_rx #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .OVERSAMPLE (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .rx_busy   (rx_busy),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #(CLK_HALF) clk = ~clk;

    initial begin
        #(8_000_000);
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int         n_tests  = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    int         exp_err  = 0;
    int         got_done = 0;
    int         got_err  = 0;
    int         busy_cnt = 0;
    logic       prev_done = 1'b0;
    logic       prev_err  = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_done++;
    endtask

    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (rst) begin
            if (prev_done) check("done_width", 32'(rx_done), 0);
            if (prev_err)  check("err_width", 32'(frame_err), 0);
            if (rx_done) begin
                got_done++;
                check("done_err_excl", 32'(frame_err), 0);
                check("done_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(exp_b));
                end
            end
            if (frame_err) got_err++;
            if (rx_data !== prev_data) check("data_only_with_done", 32'(rx_done), 1);
            if (rx_busy) busy_cnt++;
        end
        prev_done = rx_done;
        prev_err  = frame_err;
        prev_data = rx_data;
    end

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [7:0] b, input realtime bt, input logic stop_v);
        rx = 1'b0;
        #(bt);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bt);
        end
        rx = stop_v;
        #(bt);
    endtask

    task automatic send_good(input logic [7:0] b, input realtime bt);
        expect_byte(b);
        send_frame(b, bt, 1'b1);
    endtask

    task automatic idle_bits(input realtime n);
        rx = 1'b1;
        #(n * BIT_T);
    endtask

    // ---------------- stimulus ----------------
    int d0, e0;

    initial begin
        rst = 1'b0;
        rx  = 1'b1;
        #(230);
        check("reset_rx_data", 32'(rx_data), 0);
        check("reset_rx_done", 32'(rx_done), 0);
        check("reset_rx_busy", 32'(rx_busy), 0);
        check("reset_frame_err", 32'(frame_err), 0);
        check("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b1;
        idle_bits(2);

        // Single 'R' frame
        d0 = got_done; e0 = got_err; busy_cnt = 0;
        send_good(CMD_R, BIT_T);
        idle_bits(2);
        check("r_done_once", 32'(got_done - d0), 1);
        check("r_no_err", 32'(got_err - e0), 0);
        check("r_data", 32'(rx_data), 32'(CMD_R));
        check("r_busy_9p5_bits", 32'(busy_cnt >= 150 && busy_cnt <= 154), 1);

        // 'L' then 'U' back-to-back with a single stop bit
        d0 = got_done;
        send_good(CMD_L, BIT_T);
        send_good(CMD_U, BIT_T);
        idle_bits(2);
        check("b2b_two_done", 32'(got_done - d0), 2);
        check("b2b_last_data", 32'(rx_data), 32'(CMD_U));

        // 4-tick low glitch on an idle line
        d0 = got_done;
        rx = 1'b0;
        #(4 * 2 * CLK_HALF);
        rx = 1'b1;
        #(16 * 2 * CLK_HALF);
        check("glitch_busy", 32'(rx_busy), 0);
        check("glitch_state", 32'(state_dbg), 32'(IDLE));
        check("glitch_no_done", 32'(got_done - d0), 0);
        idle_bits(1);

        // Bad stop bit, line held low, then a good frame
        d0 = got_done; e0 = got_err;
        exp_err++;
        send_frame(8'hA5, BIT_T, 1'b0);
        #(3 * BIT_T);
        idle_bits(2);
        check("ferr_once", 32'(got_err - e0), 1);
        check("ferr_no_done", 32'(got_done - d0), 0);
        check("ferr_data_hold", 32'(rx_data), 32'(CMD_U));
        send_good(8'h3C, BIT_T);
        idle_bits(2);
        check("after_ferr_data", 32'(rx_data), 32'h3C);

        // Reset during data bit 4 of 0xFF
        d0 = got_done;
        fork
            send_frame(8'hFF, BIT_T, 1'b1);
            begin
                #(5.5 * BIT_T);
                rst = 1'b0;
                #(3 * 2 * CLK_HALF);
                rst = 1'b1;
            end
        join
        idle_bits(1);
        check("rst_no_done", 32'(got_done - d0), 0);
        check("rst_data_cleared", 32'(rx_data), 0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        send_good(8'h01, BIT_T);
        idle_bits(2);
        check("rst_then_01", 32'(rx_data), 32'h01);

        // Baud skew of +-2%
        d0 = got_done;
        send_good(8'h00, BIT_T / 1.02);
        idle_bits(1);
        send_good(8'hFF, BIT_T / 1.02);
        idle_bits(1);
        send_good(8'h00, BIT_T / 0.98);
        idle_bits(1);
        send_good(8'hFF, BIT_T / 0.98);
        idle_bits(2);
        check("skew_four_done", 32'(got_done - d0), 4);
        check("skew_last_data", 32'(rx_data), 32'hFF);

        // Randomized frames: random byte, skew within +-1.5%, gaps, some bad stops
        for (int n = 0; n < 24; n++) begin
            logic [7:0] b;
            int         skew;
            realtime    bt;
            b    = 8'($urandom_range(0, 255));
            skew = int'($urandom_range(0, 30)) - 15;
            bt   = BIT_T * 1000.0 / (1000.0 + real'(skew));
            if ($urandom_range(0, 7) == 0) begin
                exp_err++;
                send_frame(b, bt, 1'b0);
                #(2 * bt);
                idle_bits(1);
            end else begin
                send_good(b, bt);
            end
            if ($urandom_range(0, 1) == 1) idle_bits(real'($urandom_range(1, 3)) * 0.5);
        end

        // Drain with a bounded wait
        idle_bits(1);
        for (int c = 0; c < 2000; c++) begin
            if (exp_q.size() == 0 && !rx_busy) break;
            @(negedge clk);
        end
        check("final_queue_empty", 32'(exp_q.size()), 0);
        check("final_done_count", 32'(got_done), 32'(exp_done));
        check("final_err_count", 32'(got_err), 32'(exp_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
